// File: rtl/frame_demux_i32_o320.sv
// frame_demux_i32_o320: gathers WORDS 32-bit FIFO words into one WIDTH-bit frame
// and hands it downstream on valid/ready. Optional checker macro: TRI_CHECK_EN.
module frame_demux_i32_o320 #(
    parameter int BATCHSIZE = 10,
    parameter int BATCHNUM  = 32,
    parameter int WIDTH     = BATCHSIZE * BATCHNUM,
    parameter int WORDS     = WIDTH / 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       rd_data_count,
    input  logic [31:0]      fifo_out,
    input  logic             fifo_dout_valid,
    output logic             fifo_rd,
    output logic [WIDTH-1:0] DOUT,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             stray
`ifdef TRI_CHECK_EN
    ,
    output logic             chk_err,
    output logic [15:0]      chk_cnt
`endif
);

    localparam int WC_W = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_FULL
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WC_W-1:0]  r_rq;
    logic [WC_W-1:0]  r_wc;
    logic [WC_W-1:0]  w_wc_nxt;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] w_asm_nxt;
    logic [WIDTH-1:0] w_load_data;
    logic             w_capture;
    logic             w_done;
    logic             w_out_free;
    logic             w_load;
    logic             w_busy;

    assign w_busy     = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign w_capture  = fifo_dout_valid && w_busy && (r_wc < WC_W'(WORDS));
    assign w_wc_nxt   = r_wc + {{(WC_W-1){1'b0}}, w_capture};
    // Completion is seen in the same cycle the last word lands, so the
    // frame can move straight to DOUT without an extra bubble.
    assign w_done     = (r_state == S_DRAIN) && (w_wc_nxt == WC_W'(WORDS));
    assign w_out_free = !frame_valid || frame_ready;
    assign w_load     = (w_done && w_out_free) ||
                        ((r_state == S_FULL) && frame_ready);
    assign w_load_data = (r_state == S_FULL) ? r_asm : w_asm_nxt;

    // Assembly register view with the current word merged in
    always_comb begin
        w_asm_nxt = r_asm;
        for (int i = 0; i < WORDS; i++) begin
            if (w_capture && (r_wc == WC_W'(i))) begin
                w_asm_nxt[32*i +: 32] = fifo_out;
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (rd_data_count >= 8'(WORDS)) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_rq == WC_W'(WORDS - 1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_done) begin
                    w_state_nxt = w_out_free ? S_IDLE : S_FULL;
                end
            end
            S_FULL: begin
                if (frame_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: reads are issued only while fetching
    always_comb begin
        fifo_rd = (r_state == S_FETCH);
    end

    // Request and capture counters
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rq <= '0;
            r_wc <= '0;
        end else begin
            if ((r_state == S_FETCH) && (r_rq != WC_W'(WORDS - 1))) begin
                r_rq <= r_rq + 1'b1;
            end else begin
                r_rq <= '0;
            end
            if (w_state_nxt == S_IDLE) begin
                r_wc <= '0;
            end else begin
                r_wc <= w_wc_nxt;
            end
        end
    end

    // Assembly register captures each incoming word in place
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_asm <= '0;
        end else if (w_capture) begin
            r_asm <= w_asm_nxt;
        end
    end

    // Output frame register and valid flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            DOUT        <= '0;
            frame_valid <= 1'b0;
        end else if (w_load) begin
            DOUT        <= w_load_data;
            frame_valid <= 1'b1;
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

    // Sticky flag for data arriving when no frame is being gathered
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stray <= 1'b0;
        end else if (fifo_dout_valid &&
                     ((r_state == S_IDLE) || (r_state == S_FULL))) begin
            stray <= 1'b1;
        end
    end

`ifdef TRI_CHECK_EN
    logic                 w_chk_bad;
    logic [BATCHSIZE:0]   w_ch_new;
    logic [BATCHSIZE:0]   w_ch_old;
    logic                 r_chk_armed;

    // Each channel must step by exactly one against the previous frame;
    // the extra bit keeps 1023->0 from looking like a step.
    always_comb begin
        w_chk_bad = 1'b0;
        w_ch_new  = '0;
        w_ch_old  = '0;
        for (int k = 0; k < BATCHNUM; k++) begin
            w_ch_new = {1'b0, w_load_data[BATCHSIZE*k +: BATCHSIZE]};
            w_ch_old = {1'b0, DOUT[BATCHSIZE*k +: BATCHSIZE]};
            if ((w_ch_new != w_ch_old + (BATCHSIZE+1)'(1)) &&
                (w_ch_old != w_ch_new + (BATCHSIZE+1)'(1))) begin
                w_chk_bad = 1'b1;
            end
        end
    end

    // Error flag and saturating per-frame error count
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_chk_armed <= 1'b0;
            chk_err     <= 1'b0;
            chk_cnt     <= '0;
        end else if (w_load) begin
            r_chk_armed <= 1'b1;
            if (r_chk_armed && w_chk_bad) begin
                chk_err <= 1'b1;
                if (chk_cnt != 16'hFFFF) begin
                    chk_cnt <= chk_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_demux_i32_o320.sv
// tb_frame_demux_i32_o320: FIFO model plus frame scoreboard for the
// 32-bit to frame demux, including hold, reset and stray cases.
module tb_frame_demux_i32_o320;

    localparam int WIDTH = 320;
    localparam int WORDS = 10;

    logic             CLK = 1'b0;
    logic             RST;
    logic [7:0]       rd_data_count = 8'd0;
    logic [31:0]      fifo_out = 32'd0;
    logic             m_valid = 1'b0;
    logic             f_valid;
    logic             dv;
    logic             fifo_rd;
    logic [WIDTH-1:0] DOUT;
    logic             frame_valid;
    logic             frame_ready;
    logic             stray;
`ifdef TRI_CHECK_EN
    logic             chk_err;
    logic [15:0]      chk_cnt;
`endif

    logic [31:0]      q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_frame = '0;
    int               n_checks = 0;
    int               n_fail = 0;

    assign dv = m_valid | f_valid;

    frame_demux_i32_o320 dut (
        .CLK             (CLK),
        .RST             (RST),
        .rd_data_count   (rd_data_count),
        .fifo_out        (fifo_out),
        .fifo_dout_valid (dv),
        .fifo_rd         (fifo_rd),
        .DOUT            (DOUT),
        .frame_valid     (frame_valid),
        .frame_ready     (frame_ready),
        .stray           (stray)
`ifdef TRI_CHECK_EN
        ,
        .chk_err         (chk_err),
        .chk_cnt         (chk_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // FIFO model: data and valid one cycle after the read strobe
    always @(posedge CLK) begin
        if (fifo_rd && q.size() > 0) begin
            fifo_out <= q.pop_front();
            m_valid  <= 1'b1;
        end else begin
            m_valid  <= 1'b0;
        end
    end

    // Occupancy seen by the DUT at the next rising edge
    always @(negedge CLK) begin
        rd_data_count = 8'(q.size());
    end

    task automatic check(input string tag,
                         input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [WIDTH-1:0] mk_frame(input logic [31:0] base);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WORDS; i++) begin
            r[32*i +: 32] = base + 32'(i);
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] ch_frame(input logic [9:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            r[10*k +: 10] = v;
        end
        return r;
    endfunction

    task automatic push_frame(input logic [WIDTH-1:0] f, input bit expect_it);
        for (int i = 0; i < WORDS; i++) begin
            q.push_back(f[32*i +: 32]);
        end
        if (expect_it) begin
            exp_q.push_back(f);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge CLK);
            n++;
        end
        repeat (3) @(posedge CLK);
        #1;
        check(tag, WIDTH'(exp_q.size()), '0);
    endtask

    // Scoreboard: every accepted frame is compared in order
    always @(negedge CLK) begin
        if (RST && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_pending", WIDTH'(exp_q.size()), WIDTH'(1));
            end else begin
                last_frame = exp_q.pop_front();
                check("sb_frame", DOUT, last_frame);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_n, rd_first, fv_n, fv_first, n, bad_stable, rd_late;
        logic [31:0] lo_w, hi_w;
        logic [WIDTH-1:0] f;

        RST = 1'b0;
        frame_ready = 1'b0;
        f_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_fifo_rd", WIDTH'(fifo_rd), '0);
        check("rst_dout", DOUT, '0);
        check("rst_fv", WIDTH'(frame_valid), '0);
        check("rst_stray", WIDTH'(stray), '0);
        RST = 1'b1;

        // Single frame, output free: latency and strobe count
        @(posedge CLK);
        #1;
        frame_ready = 1'b1;
        push_frame(mk_frame(32'h0), 1'b1);
        @(posedge CLK);
        rd_n = 0; rd_first = -1; fv_n = 0; fv_first = -1;
        lo_w = '1; hi_w = '1;
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK);
            if (fifo_rd) begin
                rd_n++;
                if (rd_first < 0) rd_first = k;
            end
            if (frame_valid) begin
                fv_n++;
                if (fv_first < 0) begin
                    fv_first = k;
                    lo_w = DOUT[31:0];
                    hi_w = DOUT[319:288];
                end
            end
        end
        check("t1_rd_cycles", WIDTH'(rd_n), WIDTH'(10));
        check("t1_rd_first", WIDTH'(rd_first), '0);
        check("t1_fv_at", WIDTH'(fv_first), WIDTH'(11));
        check("t1_fv_cycles", WIDTH'(fv_n), WIDTH'(1));
        check("t1_word0", WIDTH'(lo_w), '0);
        check("t1_word9", WIDTH'(hi_w), WIDTH'(9));

        // Three frames queued with downstream stalled
        @(posedge CLK);
        #1;
        frame_ready = 1'b0;
        for (int b = 1; b <= 3; b++) begin
            push_frame(mk_frame(32'h100 * 32'(b)), 1'b1);
        end
        f = mk_frame(32'h100);
        bad_stable = 0;
        rd_late = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (k >= 15 && (DOUT !== f || frame_valid !== 1'b1)) bad_stable++;
            if (k >= 35 && fifo_rd) rd_late++;
        end
        check("t2_stable", WIDTH'(bad_stable), '0);
        check("t2_no_rd", WIDTH'(rd_late), '0);
        check("t2_count", WIDTH'(rd_data_count), WIDTH'(10));
        @(posedge CLK);
        #1;
        frame_ready = 1'b1;
        wait_drain("t2_drain");

        // Count just under a frame holds off the fetch
        @(posedge CLK);
        #1;
        f = mk_frame(32'h400);
        for (int i = 0; i < WORDS - 1; i++) q.push_back(f[32*i +: 32]);
        rd_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (fifo_rd) rd_n++;
        end
        check("t3_no_rd", WIDTH'(rd_n), '0);
        check("t3_count9", WIDTH'(rd_data_count), WIDTH'(9));
        @(posedge CLK);
        #1;
        q.push_back(f[319:288]);
        exp_q.push_back(f);
        @(negedge CLK);
        check("t3_pre", WIDTH'(fifo_rd), '0);
        @(posedge CLK);
        @(negedge CLK);
        check("t3_go", WIDTH'(fifo_rd), WIDTH'(1));
        wait_drain("t3_drain");

        // Valid forced while idle
        @(posedge CLK);
        #1;
        check("t5_stray0", WIDTH'(stray), '0);
        f_valid = 1'b1;
        @(posedge CLK);
        #1;
        f_valid = 1'b0;
        @(negedge CLK);
        check("t5_stray1", WIDTH'(stray), WIDTH'(1));
        check("t5_dout", DOUT, last_frame);
        check("t5_fv", WIDTH'(frame_valid), '0);

        // Reset in the middle of a fetch
        @(posedge CLK);
        #1;
        push_frame(mk_frame(32'h500), 1'b0);
        n = 0;
        for (int g = 0; g < 50 && n < 5; g++) begin
            @(posedge CLK);
            if (fifo_rd) n++;
        end
        check("t4_rd5", WIDTH'(n), WIDTH'(5));
        #1;
        RST = 1'b0;
        #1;
        check("t4_rd_async", WIDTH'(fifo_rd), '0);
        check("t4_dout0", DOUT, '0);
        check("t4_stray0", WIDTH'(stray), '0);
        #2;
        RST = 1'b1;
        q.delete();
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("t4_stray1", WIDTH'(stray), WIDTH'(1));
        check("t4_no_fv", WIDTH'(frame_valid), '0);
        @(posedge CLK);
        #1;
        push_frame(mk_frame(32'h600), 1'b1);
        wait_drain("t4_after");

`ifdef TRI_CHECK_EN
        // Triangle checker: clean ramp, then one broken channel
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #2;
        RST = 1'b1;
        push_frame(ch_frame(10'd5), 1'b1);
        push_frame(ch_frame(10'd6), 1'b1);
        push_frame(ch_frame(10'd7), 1'b1);
        wait_drain("tc_drain3");
        check("tc_err0", WIDTH'(chk_err), '0);
        check("tc_cnt0", WIDTH'(chk_cnt), '0);
        f = ch_frame(10'd8);
        f[39:30] = 10'd9;
        push_frame(f, 1'b1);
        wait_drain("tc_drain4");
        check("tc_err1", WIDTH'(chk_err), WIDTH'(1));
        check("tc_cnt1", WIDTH'(chk_cnt), WIDTH'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_demux_i32_o320.md
# frame_demux_i32_o320

Reassembles wide sample frames from the 32-bit words stored in the readout FIFO, as the inverse of the 320→32 word mux. It drains the FIFO with a read strobe and gathers `WORDS` consecutive words into one `WIDTH`-bit frame. It presents each completed frame to downstream logic (loop-back checker, closed-loop processing) on a valid/ready handshake. A second assembly register lets the next frame be fetched while the current one waits on the handshake.

## Interface
Parameters:
- `BATCHSIZE`, 10, bits per channel sample.
- `BATCHNUM`, 32, channels per frame.
- `WIDTH`, `BATCHSIZE*BATCHNUM` (320), frame width.
- `WORDS`, `WIDTH/32` (10), FIFO words per frame; `WIDTH` must be a multiple of 32.

Ports:
- `CLK` input 1: single clock, shared with the FIFO read side.
- `RST` input 1: asynchronous, active-low reset.
- `rd_data_count` input 8: FIFO read-side occupancy.
- `fifo_out` input 32: FIFO read data.
- `fifo_dout_valid` input 1: `fifo_out` is valid this cycle; it arrives 1 cycle after `fifo_rd`.
- `fifo_rd` output 1: FIFO read enable.
- `DOUT` output `WIDTH`: current frame.
- `frame_valid` output 1: `DOUT` holds a frame.
- `frame_ready` input 1: downstream accepts the frame.
- `stray` output 1: sticky flag for unexpected `fifo_dout_valid`.
- `chk_err` output 1, `chk_cnt` output 16: present only with `TRI_CHECK_EN` (see Configuration).

## Operation
- Packing:
  - Word i (0-based, in FIFO order) lands in `DOUT[32i+31:32i]`.
  - Channel k occupies `DOUT[10k+9:10k]`.
- Assembly FSM states:
  - IDLE → FETCH when `rd_data_count >= WORDS` and the assembly register is free.
  - FETCH: assert `fifo_rd` for exactly `WORDS` consecutive cycles, counted by request counter `rq` from 0 to `WORDS-1`, then → DRAIN.
  - DRAIN: keep capturing on `fifo_dout_valid`. When capture counter `wc` reaches `WORDS`:
    - → IDLE, with the assembly register copied to `DOUT` and `frame_valid` set, if the output is free or is being accepted this cycle (`frame_valid & frame_ready`);
    - otherwise → FULL.
  - FULL: no reads issued. On `frame_ready` the assembly register transfers to `DOUT` with `frame_valid` kept at 1, then → IDLE.
- Capture: words are taken only while `wc < WORDS` in FETCH or DRAIN. `fifo_dout_valid` in IDLE or FULL is ignored and sets `stray`, which is cleared only by reset.
- Output handshake:
  - A frame transfers on a cycle with `frame_valid & frame_ready`.
  - `frame_valid` drops the next cycle unless a new frame is loaded that same cycle.
  - `DOUT` is stable while `frame_valid` is high and `frame_ready` is low.
- Assumption for `rd_data_count`: a count of `WORDS` or more at FETCH entry guarantees no underflow. The block does not re-check the count during FETCH.

## Timing
- Reset values: `fifo_rd`=0, `DOUT`=0, `frame_valid`=0, `stray`=0, `chk_err`=0, `chk_cnt`=0. FSM in IDLE, `rq`=`wc`=0.
- Latency, with `rd_data_count >= WORDS` sampled at cycle t:
  - `fifo_rd` is high at cycles t+1 through t+`WORDS`.
  - Words are captured at t+2 through t+`WORDS`+1.
  - `frame_valid` is high at t+`WORDS`+2 when the output is free.
- Back-to-back: IDLE re-evaluates the count in the cycle after the transfer into `DOUT`. Sustained throughput is one frame per `WORDS`+2 cycles.
- Simultaneous events:
  - Assembly completing in the same cycle the old frame is accepted: the new frame loads directly and `frame_valid` stays 1.
  - `frame_ready` while `frame_valid` is 0: ignored.
- Reset mid-frame: partial words are discarded and `fifo_rd` drops asynchronously. Words still in flight after reset release arrive in IDLE and set `stray`.

## Configuration
- `TRI_CHECK_EN` defined: a triangle-continuity checker is compiled in.
  - On every frame transfer into `DOUT`, each channel's new 10-bit value is compared with that channel's value in the previous frame.
  - The absolute difference must equal 1, with no modular wrap: 0→1023 is an error.
  - On the first frame after reset the previous values are only loaded, not checked.
  - Any mismatching frame sets sticky `chk_err` and increments `chk_cnt` by 1, once per frame regardless of how many channels mismatch. `chk_cnt` saturates at 0xFFFF.
- `TRI_CHECK_EN` undefined: the `chk_err` and `chk_cnt` ports and all checker logic are absent.

## Test plan
- FIFO preloaded with words 0x0..0x9, `frame_ready`=1 → exactly 10 `fifo_rd` cycles, then `frame_valid` for one cycle with `DOUT[31:0]`=0x0 and `DOUT[319:288]`=0x9, at t+12.
- 30 preloaded words, `frame_ready`=0 for 50 cycles → frame 1 held stable in `DOUT`, frame 2 assembled and held in FULL, `fifo_rd` stays 0 and `rd_data_count` stays at 10. Releasing `frame_ready` yields frames 2 and 3 in order.
- `rd_data_count`=9 held → `fifo_rd` never asserts. Raising the count to 10 → the fetch starts on the next cycle.
- `RST` pulsed low after the 5th `fifo_rd` → `fifo_rd`=0 immediately and no frame emitted. The in-flight word sets `stray`=1. A subsequent full frame assembles correctly.
- `fifo_dout_valid` forced high in IDLE → `stray`=1, `DOUT` and `frame_valid` unchanged.
- With `TRI_CHECK_EN`:
  - three frames with all channels 5, 6, 7 → `chk_err`=0, `chk_cnt`=0;
  - a 4th frame with channel 3 = 9 → `chk_err`=1, `chk_cnt`=1.
